// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, completion error codes,
// bus response values and the store FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_BUS      = 2'b11;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUS    = 2'b01,
        ST_WAIT_B = 2'b10,
        ST_RESP   = 2'b11
    } store_state_t;

endpackage

// File: rtl/store_encoder.sv
// Combinational SB/SH/SW encoder: byte offset and rs2 value to lane-replicated
// write data, byte strobes and fault flags.
module store_encoder
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    always_comb begin
        wdata_o      = data_i;
        wstrb_o      = 4'h0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_SB: begin
                wdata_o = {4{data_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            F3_SH: begin
                wdata_o      = {2{data_i[15:0]}};
                wstrb_o      = 4'b0011 << addr_lo_i;
                misaligned_o = addr_lo_i[0];
            end
            F3_SW: begin
                wdata_o      = data_i;
                wstrb_o      = 4'hF;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: begin
                // Misalignment is only meaningful for a known access size.
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store path: latches one encoded store, drives it on the AW/W/B bus and
// reports a single-cycle completion with an error code.
module store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [2:0]          req_funct3,
    output logic                done,
    output logic [1:0]          err,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp
);

    localparam int STRB_W = DATA_W / 8;

    store_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic [1:0]          err_q, err_d;

    logic [DATA_W-1:0]   enc_wdata;
    logic [STRB_W-1:0]   enc_wstrb;
    logic                enc_misaligned;
    logic                enc_illegal;

    store_encoder u_enc (
        .addr_lo_i    (req_addr[1:0]),
        .data_i       (req_data),
        .funct3_i     (req_funct3),
        .wdata_o      (enc_wdata),
        .wstrb_o      (enc_wstrb),
        .misaligned_o (enc_misaligned),
        .illegal_o    (enc_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        err_d     = err_q;
        req_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    awaddr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d  = enc_wdata;
                    wstrb_d  = enc_wstrb;
                    if (enc_misaligned) begin
                        err_d   = ERR_MISALIGN;
                        state_d = ST_RESP;
                    end else if (enc_illegal) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_RESP;
                    end else begin
                        err_d     = ERR_OK;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                // AW and W retire independently; leave only when both have.
                awvalid   = aw_pend_q;
                wvalid    = w_pend_q;
                aw_pend_d = aw_pend_q && !awready;
                w_pend_d  = w_pend_q && !wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_d   = (bresp == BRESP_OKAY) ? ERR_OK : ERR_BUS;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign awaddr = awaddr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign err    = done ? err_q : ERR_OK;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: directed stores push expectations, a monitor
// checks each completion plus bus handshakes, latency and stability.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [2:0]  req_funct3;
    logic        done;
    logic [1:0]  err;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_funct3 (req_funct3),
        .done       (done),
        .err        (err),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] awaddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          n_bus;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endfunction

    // Bus slave knobs
    int   aw_delay = 0, w_delay = 0, b_delay = 0;
    bit   b_early = 0;
    logic [1:0] bresp_val = 2'b00;
    int   aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (bready) begin bvalid = (b_cnt >= b_delay); b_cnt++; end
            else begin bvalid = b_early && (awvalid || wvalid); b_cnt = 0; end
            bresp = bresp_val;
        end
    end

    // Monitor / scoreboard
    int          cyc = 0, start_cyc = 0;
    int          aw_n = 0, w_n = 0, b_n = 0;
    bit          busy = 0, prev_done = 0;
    bit          prev_aw_wait = 0, prev_w_wait = 0;
    logic [31:0] prev_awaddr, prev_wdata, cap_awaddr, cap_wdata;
    logic [3:0]  prev_wstrb, cap_wstrb;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy = 0; prev_done = 0; aw_n = 0; w_n = 0; b_n = 0;
                prev_aw_wait = 0; prev_w_wait = 0;
                exp_q.delete();
            end else begin
                if (prev_aw_wait) chk("awaddr_stable", awaddr, prev_awaddr);
                if (prev_w_wait) begin
                    chk("wdata_stable", wdata, prev_wdata);
                    chk("wstrb_stable", {28'h0, wstrb}, {28'h0, prev_wstrb});
                end
                prev_aw_wait = awvalid && !awready;
                prev_w_wait  = wvalid && !wready;
                prev_awaddr  = awaddr;
                prev_wdata   = wdata;
                prev_wstrb   = wstrb;
                if (awvalid && awready) begin aw_n++; cap_awaddr = awaddr; end
                if (wvalid && wready) begin w_n++; cap_wdata = wdata; cap_wstrb = wstrb; end
                if (bvalid && bready) b_n++;
                if (busy) chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
                if (done) begin
                    chk("done_pulse", {31'h0, prev_done}, 32'h0);
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", {31'h0, done}, 32'h0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("err", {30'h0, err}, {30'h0, e.err});
                        chk("latency", cyc - start_cyc, e.lat);
                        chk("aw_count", aw_n, e.n_bus);
                        chk("w_count", w_n, e.n_bus);
                        chk("b_count", b_n, e.n_bus);
                        if (e.n_bus != 0) begin
                            chk("awaddr", cap_awaddr, e.awaddr);
                            chk("wdata", cap_wdata, e.wdata);
                            chk("wstrb", {28'h0, cap_wstrb}, {28'h0, e.wstrb});
                        end
                    end
                    aw_n = 0; w_n = 0; b_n = 0; busy = 0;
                end
                prev_done = done;
                if (req_valid && req_ready) begin busy = 1; start_cyc = cyc; end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic [1:0] e_err, input logic [31:0] e_awaddr,
                         input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                         input int e_bus, input int e_lat);
        exp_t e;
        bit   acc;
        int   n;
        e.err = e_err; e.awaddr = e_awaddr; e.wdata = e_wdata; e.wstrb = e_wstrb;
        e.n_bus = e_bus; e.lat = e_lat;
        exp_q.push_back(e);
        req_addr = a; req_data = d; req_funct3 = f3; req_valid = 1;
        acc = 0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("accept_timeout", {31'h0, acc}, 32'h1);
    endtask

    task automatic wait_idle();
        int n = 0;
        req_valid = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("idle_timeout", {31'h0, exp_q.size() == 0}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst_n = 0; req_valid = 0; req_addr = 0; req_data = 0; req_funct3 = 0;
        #3;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_valids", {29'h0, awvalid, wvalid, bready}, 32'h0);
        chk("rst_err", {30'h0, err}, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_wstrb", {28'h0, wstrb}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Byte / half / word encodes, zero-wait bus
        issue(32'h8000_0003, 32'h1234_56AB, 3'b000, 2'b00, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 1, 3);
        wait_idle();
        issue(32'h4000_0001, 32'h0000_005A, 3'b000, 2'b00, 32'h4000_0000, 32'h5A5A_5A5A, 4'b0010, 1, 3);
        wait_idle();
        issue(32'h1000_0002, 32'hDEAD_BEEF, 3'b001, 2'b00, 32'h1000_0000, 32'hBEEF_BEEF, 4'b1100, 1, 3);
        wait_idle();
        issue(32'h4000_0000, 32'h0000_1234, 3'b001, 2'b00, 32'h4000_0000, 32'h1234_1234, 4'b0011, 1, 3);
        wait_idle();

        // Fault paths: no bus activity, done one cycle after acceptance
        issue(32'h1000_0001, 32'hDEAD_BEEF, 3'b001, 2'b01, 32'h0, 32'h0, 4'h0, 0, 1);
        wait_idle();
        issue(32'h2000_0002, 32'h0, 3'b010, 2'b01, 32'h0, 32'h0, 4'h0, 0, 1);
        wait_idle();
        issue(32'h3000_0000, 32'h0, 3'b011, 2'b10, 32'h0, 32'h0, 4'h0, 0, 1);
        wait_idle();
        issue(32'h3000_0001, 32'h0, 3'b111, 2'b10, 32'h0, 32'h0, 4'h0, 0, 1);
        wait_idle();

        // W ready immediately, AW held three extra cycles
        aw_delay = 3;
        issue(32'h2000_0000, 32'hCAFE_F00D, 3'b010, 2'b00, 32'h2000_0000, 32'hCAFE_F00D, 4'hF, 1, 6);
        wait_idle();
        aw_delay = 0;

        // AW first, W late, bvalid offered early and must be ignored
        w_delay = 2; b_delay = 1; b_early = 1;
        issue(32'h2000_0010, 32'h0BAD_F00D, 3'b010, 2'b00, 32'h2000_0010, 32'h0BAD_F00D, 4'hF, 1, 6);
        wait_idle();
        w_delay = 0; b_delay = 0; b_early = 0;

        // Bus error response
        bresp_val = 2'b10;
        issue(32'h3000_0004, 32'h0102_0304, 3'b010, 2'b11, 32'h3000_0004, 32'h0102_0304, 4'hF, 1, 3);
        wait_idle();
        bresp_val = 2'b00;

        // Reset while waiting for B
        b_delay = 30;
        issue(32'h7000_0000, 32'h5555_AAAA, 3'b010, 2'b00, 32'h7000_0000, 32'h5555_AAAA, 4'hF, 1, 3);
        req_valid = 0;
        n = 0;
        while (!bready && n < 50) begin @(negedge clk); n++; end
        chk("reach_wait_b", {31'h0, bready}, 32'h1);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_valids", {29'h0, awvalid, wvalid, bready}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        b_delay = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        issue(32'h5000_0002, 32'h0000_0077, 3'b000, 2'b00, 32'h5000_0000, 32'h7777_7777, 4'b0100, 1, 3);
        wait_idle();

        // Back-to-back with req_valid held across requests
        issue(32'h6000_0008, 32'h1111_2222, 3'b010, 2'b00, 32'h6000_0008, 32'h1111_2222, 4'hF, 1, 3);
        issue(32'h6000_000D, 32'hFFFF_FF99, 3'b000, 2'b00, 32'h6000_000C, 32'h9999_9999, 4'b0010, 1, 3);
        issue(32'h6000_0003, 32'h0000_4444, 3'b001, 2'b01, 32'h0, 32'h0, 4'h0, 0, 1);
        wait_idle();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
